lite_regfile_peripheral: RTL

LITE_REGFILE_PERIPHERAL -- requirements
Module: lite_regfile_peripheral

---
 rtl/lite_periph_pkg.sv | 20 ++
 rtl/lite_compute_unit.sv | 23 ++
 rtl/lite_regfile_peripheral.sv | 131 +++++++++++++
 3 files changed

// File: rtl/lite_periph_pkg.sv
// Shared types and constants for the register-file peripheral and its compute unit.
package lite_periph_pkg;

    localparam int CTRL_ADDR = 0;
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        HALF         = 2'd0,
        TRIPLE_PLUS1 = 2'd1,
        IDENT        = 2'd2,
        INVERT       = 2'd3
    } mode_e;

endpackage

// File: rtl/lite_compute_unit.sv
// Combinational function f(a) served for reads of the compute region; results wrap at DATA_W.
module lite_compute_unit
    import lite_periph_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  mode_e             mode,
    input  logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] f
);

    always_comb begin
        f = a;
        case (mode)
            HALF:         f = a >> 1;
            TRIPLE_PLUS1: f = a + a + a + DATA_W'(1);
            IDENT:        f = a;
            INVERT:       f = ~a;
            default:      f = a;
        endcase
    end

endmodule

// File: rtl/lite_regfile_peripheral.sv
// Request/response register-file peripheral: CTRL, scratch flops and a compute region.
//   state  | meaning
//   S_IDLE | waiting for trans; request captured on accept
//   S_WAIT | counting down the configured wait states
//   S_RESP | readyout high for one cycle; writes commit on the closing edge
module lite_regfile_peripheral
    import lite_periph_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4,
    parameter int WAIT   = 1
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              trans,
    input  logic              write,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic              readyout,
    output logic [DATA_W-1:0] rdata,
    output logic              err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'((WAIT > 0) ? WAIT - 1 : 0);
    localparam logic [ADDR_W-1:0] SCR_LAST = ADDR_W'(DEPTH);

    state_e                state;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  cap_write;
    logic [ADDR_W-1:0]     cap_addr;
    logic [DATA_W-1:0]     cap_wdata;
    mode_e                 mode;
    logic [DATA_W-1:0]     scratch [DEPTH];

    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              is_ctrl;
    logic              is_scr;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] f_out;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;

    // With no wait states the response is formed on the accept edge, so decode the live inputs then.
    assign req_write = (state == S_IDLE) ? write : cap_write;
    assign req_addr  = (state == S_IDLE) ? waddr : cap_addr;
    assign req_wdata = (state == S_IDLE) ? wdata : cap_wdata;

    assign is_ctrl = (req_addr == ADDR_W'(CTRL_ADDR));
    assign is_scr  = !is_ctrl && (req_addr <= SCR_LAST);
    assign idx     = IDX_W'(req_addr - ADDR_W'(1));

    lite_compute_unit #(.DATA_W(DATA_W)) u_compute (
        .mode (mode),
        .a    (DATA_W'(req_addr)),
        .f    (f_out)
    );

    always_comb begin
        resp_data = '0;
        resp_err  = 1'b0;
        if (req_write) begin
            if (is_ctrl || is_scr) resp_data = req_wdata;
            else                   resp_err  = 1'b1;
        end else if (is_ctrl) begin
            resp_data = DATA_W'(mode);
        end else if (is_scr) begin
            resp_data = scratch[idx];
        end else begin
            resp_data = f_out;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            cap_write <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            mode      <= HALF;
            readyout  <= 1'b0;
            rdata     <= '0;
            err       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) scratch[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (trans) begin
                        cap_write <= write;
                        cap_addr  <= waddr;
                        cap_wdata <= wdata;
                        if (WAIT == 0) begin
                            state    <= S_RESP;
                            readyout <= 1'b1;
                            rdata    <= resp_data;
                            err      <= resp_err;
                        end else begin
                            state    <= S_WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        state    <= S_RESP;
                        readyout <= 1'b1;
                        rdata    <= resp_data;
                        err      <= resp_err;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    state    <= S_IDLE;
                    readyout <= 1'b0;
                    err      <= 1'b0;
                    if (cap_write) begin
                        if (is_ctrl)     mode         <= mode_e'(cap_wdata[1:0]);
                        else if (is_scr) scratch[idx] <= cap_wdata;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
